vga_line_buffer: RTL

Ping-pong scanline buffer between a pixel producer and the 800x600@60Hz VGA timing/colour stage. A producer writes whole lines of 12-bit RGB pixels through a valid/ready handshake. The VGA stage consumes them one pixel per visible clock, replacing its built-in test pattern. Everything runs on the VGA pixel clock.

---
 rtl/vga_line_buffer_if.sv | 24 ++
 rtl/vga_line_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_buffer_if.sv
// rtl/vga_line_buffer_if.sv - pixel write stream from producer into the scanline buffer
interface vga_line_buffer_if #(
  parameter int PIX_W = 12
);
  logic             wr_valid;
  logic             wr_ready;
  logic [PIX_W-1:0] wr_data;
  logic             wr_last;

  // producer side drives pixels, buffer answers with ready
  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/vga_line_buffer.sv
// rtl/vga_line_buffer.sv - ping-pong scanline buffer feeding the VGA colour stage; VGA_LINE_BUFFER_STATS_EN enables underflow_count
module vga_line_buffer #(
  parameter int H_RES = 800,
  parameter int PIX_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_line_buffer_if.slave     wr,
  input  logic                 line_start,
  input  logic                 rd_en,
  input  logic                 clear_status,
  output logic [PIX_W-1:0]     rd_data,
  output logic                 underflow,
  output logic                 overrun,
  output logic [15:0]          underflow_count
);

  localparam int IDX_W = $clog2(H_RES + 1);
  localparam logic [IDX_W-1:0] H_RES_IDX = IDX_W'(H_RES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(H_RES - 1);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  // per-bank state and stored line length
  logic [1:0]       bank_st   [2];
  logic [1:0]       st_w      [2];
  logic [1:0]       bank_st_n [2];
  logic [IDX_W-1:0] bank_len  [2];

  // pixel storage, one array per bank
  logic [PIX_W-1:0] mem0 [H_RES];
  logic [PIX_W-1:0] mem1 [H_RES];

  // write side
  logic             wr_bank;
  logic [IDX_W-1:0] wr_cnt;
  logic             discarding;
  logic             wr_accept;
  logic             wr_store;
  logic             wr_close;
  logic             wr_trunc;
  logic             wr_toggle;

  // read side
  logic             rd_bank;
  logic             rd_active;
  logic [IDX_W-1:0] rd_idx;
  logic             sel_valid;
  logic             sel_bank;
  logic             underflow_set;
  logic [PIX_W-1:0] rd_word;

  // ready depends only on the write bank state, never on wr_valid
  assign wr.wr_ready = discarding ||
                       (bank_st[wr_bank] == ST_EMPTY) ||
                       (bank_st[wr_bank] == ST_FILLING);

  assign wr_accept = wr.wr_valid && wr.wr_ready;
  assign wr_store  = wr_accept && !discarding;
  // the 800th stored beat closes the bank whether or not it carries last
  assign wr_close  = wr_store && (wr.wr_last || (wr_cnt == LAST_IDX));
  assign wr_trunc  = wr_store && !wr.wr_last && (wr_cnt == LAST_IDX);
  // the pointer moves only once the producer's line really ends
  assign wr_toggle = wr_accept && wr.wr_last;

  // bank states after the write side acts; closes are seen by line_start this cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_w[b] = bank_st[b];
      if (wr_store && (wr_bank == 1'(b))) begin
        st_w[b] = wr_close ? ST_FULL : ST_FILLING;
      end
    end
  end

  // line_start frees the draining bank and picks the oldest full bank, alternating
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_n[b] = st_w[b];
    end
    sel_valid = 1'b0;
    sel_bank  = ~rd_bank;
    if (line_start) begin
      for (int b = 0; b < 2; b++) begin
        if (st_w[b] == ST_DRAINING) begin
          bank_st_n[b] = ST_EMPTY;
        end
      end
      if (bank_st_n[~rd_bank] == ST_FULL) begin
        sel_valid = 1'b1;
        sel_bank  = ~rd_bank;
      end else if (bank_st_n[rd_bank] == ST_FULL) begin
        sel_valid = 1'b1;
        sel_bank  = rd_bank;
      end
      for (int b = 0; b < 2; b++) begin
        if (sel_valid && (sel_bank == 1'(b))) begin
          bank_st_n[b] = ST_DRAINING;
        end
      end
    end
  end

  assign underflow_set = line_start && !sel_valid;

  // bank state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
    end else begin
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
    end
  end

  // write pointer, beat counter, discard mode and stored lengths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      discarding  <= 1'b0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
    end else begin
      if (wr_store) begin
        wr_cnt <= wr_close ? '0 : wr_cnt + 1'b1;
      end
      if (wr_close) begin
        // truncation happens at count H_RES-1, so count+1 covers both cases
        bank_len[wr_bank] <= wr_cnt + 1'b1;
      end
      if (wr_trunc) begin
        discarding <= 1'b1;
      end else if (discarding && wr_accept && wr.wr_last) begin
        discarding <= 1'b0;
      end
      if (wr_toggle) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // pixel storage writes; contents are don't-care until a bank length covers them
  always_ff @(posedge clk) begin
    if (wr_store) begin
      if (wr_bank) begin
        mem1[wr_cnt[IDX_W-1:0]] <= wr.wr_data;
      end else begin
        mem0[wr_cnt[IDX_W-1:0]] <= wr.wr_data;
      end
    end
  end

  // read bank selection and saturating read index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank   <= 1'b1;
      rd_active <= 1'b0;
      rd_idx    <= '0;
    end else if (line_start) begin
      rd_idx    <= '0;
      rd_active <= sel_valid;
      if (sel_valid) begin
        rd_bank <= sel_bank;
      end
    end else if (rd_en && (rd_idx != H_RES_IDX)) begin
      rd_idx <= rd_idx + 1'b1;
    end
  end

  assign rd_word = rd_bank ? mem1[rd_idx] : mem0[rd_idx];

  // registered pixel output, zero outside the stored part of a draining bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en && rd_active && (rd_idx < bank_len[rd_bank])) begin
      rd_data <= rd_word;
    end else begin
      rd_data <= '0;
    end
  end

  // sticky status flags; a new event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (clear_status) begin
        underflow <= 1'b0;
      end
      if (wr_trunc) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef VGA_LINE_BUFFER_STATS_EN
  logic [15:0] uf_cnt;

  // saturating underflowed-line counter; clear plus new underflow leaves one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_cnt <= 16'd0;
    end else if (underflow_set) begin
      if (clear_status) begin
        uf_cnt <= 16'd1;
      end else if (uf_cnt != 16'hFFFF) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end else if (clear_status) begin
      uf_cnt <= 16'd0;
    end
  end

  assign underflow_count = uf_cnt;
`else
  assign underflow_count = 16'd0;
`endif

endmodule
